// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access-size encodings,
// RAM read latency, response-stage context and byte-enable helpers.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int RD_LATENCY = 1;

  typedef struct packed {
    logic       port;
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
    logic       err;
  } rsp_ctx_t;

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SIZE_B:  be = 4'b0001 << off;
      SIZE_H:  be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Size 2'b11 behaves as a word, so bit 1 alone identifies word accesses.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SIZE_H) && off[0]) || (size[1] && (off != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational byte-lane formatter: replicates store data across lanes, or
// extracts and sign/zero-extends the addressed lane of a loaded word.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic        load_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  logic [7:0]  lane_b_s;
  logic [15:0] lane_h_s;

  // Lane selection and extension
  always_comb begin
    data_o   = data_i;
    lane_b_s = 8'h00;
    lane_h_s = 16'h0000;
    if (load_i) begin
      case (off_i)
        2'b00:   lane_b_s = data_i[7:0];
        2'b01:   lane_b_s = data_i[15:8];
        2'b10:   lane_b_s = data_i[23:16];
        default: lane_b_s = data_i[31:24];
      endcase
      lane_h_s = off_i[1] ? data_i[31:16] : data_i[15:0];
      case (size_i)
        SIZE_B:  data_o = unsigned_i ? {24'h000000, lane_b_s} : {{24{lane_b_s[7]}}, lane_b_s};
        SIZE_H:  data_o = unsigned_i ? {16'h0000, lane_h_s} : {{16{lane_h_s[15]}}, lane_h_s};
        default: data_o = data_i;
      endcase
    end else begin
      case (size_i)
        SIZE_B:  data_o = {4{data_i[7:0]}};
        SIZE_H:  data_o = {2{data_i[15:0]}};
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) round-robin arbiter onto one synchronous single-port RAM
// with byte-lane formatting. Optional misalignment errors: DMEM_ARB_ERR_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_we,
  input  logic [31:0]           p0_req_addr,
  input  logic [31:0]           p0_req_wdata,
  input  logic [1:0]            p0_req_size,
  input  logic                  p0_req_unsigned,
  output logic                  p0_resp_valid,
  output logic [31:0]           p0_resp_rdata,
  output logic                  p0_resp_err,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_we,
  input  logic [31:0]           p1_req_addr,
  input  logic [31:0]           p1_req_wdata,
  input  logic [1:0]            p1_req_size,
  input  logic                  p1_req_unsigned,
  output logic                  p1_resp_valid,
  output logic [31:0]           p1_resp_rdata,
  output logic                  p1_resp_err,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  input  logic [31:0]           mem_dout
);

  logic                  grant_s, gnt_port_s, mis_s, resp_live_s, unused_addr_s;
  logic                  sel_we_s, sel_uns_s;
  logic [1:0]            sel_size_s;
  logic [31:0]           sel_addr_s, sel_wdata_s, st_data_s, ld_data_s;
  logic                  prio_q, prio_d;
  logic [RD_LATENCY-1:0] pend_q, pend_d;
  rsp_ctx_t              ctx_q, ctx_d;

  // Arbitration: prio_q names the port that wins a tie
  always_comb begin
    if (p0_req_valid && p1_req_valid) begin
      gnt_port_s = prio_q;
    end else if (p1_req_valid) begin
      gnt_port_s = 1'b1;
    end else begin
      gnt_port_s = 1'b0;
    end
    grant_s = rst & (p0_req_valid | p1_req_valid);
    if (gnt_port_s) begin
      sel_we_s = p1_req_we; sel_addr_s = p1_req_addr; sel_wdata_s = p1_req_wdata;
      sel_size_s = p1_req_size; sel_uns_s = p1_req_unsigned;
    end else begin
      sel_we_s = p0_req_we; sel_addr_s = p0_req_addr; sel_wdata_s = p0_req_wdata;
      sel_size_s = p0_req_size; sel_uns_s = p0_req_unsigned;
    end
  end

  assign p0_req_ready  = grant_s & ~gnt_port_s;
  assign p1_req_ready  = grant_s & gnt_port_s;
  assign unused_addr_s = ^sel_addr_s[31:ADDR_WIDTH+2];

`ifdef DMEM_ARB_ERR_EN
  assign mis_s = is_misaligned(sel_size_s, sel_addr_s[1:0]);
`else
  assign mis_s = 1'b0;
`endif

  dmem_lane_fmt u_st_fmt (
    .load_i     (1'b0),
    .size_i     (sel_size_s),
    .unsigned_i (sel_uns_s),
    .off_i      (sel_addr_s[1:0]),
    .data_i     (sel_wdata_s),
    .data_o     (st_data_s)
  );

  // RAM request issued in the grant cycle; misaligned requests never reach the RAM
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 4'b0000;
    mem_addr = {ADDR_WIDTH{1'b0}};
    mem_din  = 32'h0000_0000;
    if (grant_s && !mis_s) begin
      mem_en   = 1'b1;
      mem_addr = sel_addr_s[ADDR_WIDTH+1:2];
      if (sel_we_s) begin
        mem_we  = store_be(sel_size_s, sel_addr_s[1:0]);
        mem_din = st_data_s;
      end else begin
        mem_we  = 4'b0000;
        mem_din = 32'h0000_0000;
      end
    end else begin
      mem_en = 1'b0;
    end
  end

  // Next-state for pointer and response stage
  always_comb begin
    prio_d = prio_q;
    ctx_d  = ctx_q;
    pend_d = {RD_LATENCY{1'b0}};
    if (grant_s) begin
      prio_d = ~gnt_port_s;
      ctx_d  = '{port: gnt_port_s, size: sel_size_s, uns: sel_uns_s,
                 off: sel_addr_s[1:0], err: mis_s};
      pend_d = RD_LATENCY'(~sel_we_s | mis_s);
    end else begin
      prio_d = prio_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_q <= 1'b0;
      pend_q <= {RD_LATENCY{1'b0}};
      ctx_q  <= '0;
    end else begin
      prio_q <= prio_d;
      pend_q <= pend_d;
      ctx_q  <= ctx_d;
    end
  end

  dmem_lane_fmt u_ld_fmt (
    .load_i     (1'b1),
    .size_i     (ctx_q.size),
    .unsigned_i (ctx_q.uns),
    .off_i      (ctx_q.off),
    .data_i     (mem_dout),
    .data_o     (ld_data_s)
  );

  // Response steering; gating with rst keeps outputs at zero during reset
  always_comb begin
    resp_live_s   = rst & pend_q[RD_LATENCY-1];
    p0_resp_valid = resp_live_s & ~ctx_q.port;
    p1_resp_valid = resp_live_s & ctx_q.port;
    p0_resp_rdata = (p0_resp_valid && !ctx_q.err) ? ld_data_s : 32'h0000_0000;
    p1_resp_rdata = (p1_resp_valid && !ctx_q.err) ? ld_data_s : 32'h0000_0000;
  end

`ifdef DMEM_ARB_ERR_EN
  assign p0_resp_err = p0_resp_valid & ctx_q.err;
  assign p1_resp_err = p1_resp_valid & ctx_q.err;
`else
  assign p0_resp_err = 1'b0;
  assign p1_resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a shadow memory model predicts RAM
// requests and load responses; define DMEM_ARB_ERR_EN to cover error responses.
module tb_dmem_arbiter;
  localparam int AW = 14;

  typedef struct {
    bit          port;
    logic [31:0] data;
    bit          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req_valid, p0_req_ready, p0_req_we, p0_req_unsigned;
  logic [31:0]   p0_req_addr, p0_req_wdata, p0_resp_rdata;
  logic [1:0]    p0_req_size;
  logic          p0_resp_valid, p0_resp_err;
  logic          p1_req_valid, p1_req_ready, p1_req_we, p1_req_unsigned;
  logic [31:0]   p1_req_addr, p1_req_wdata, p1_resp_rdata;
  logic [1:0]    p1_req_size;
  logic          p1_resp_valid, p1_resp_err;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din, mem_dout;

  logic [31:0] ram    [0:(1<<AW)-1];
  logic [31:0] shadow [0:(1<<AW)-1];
  exp_t        sb_q[$];
  bit          tb_prio;
  int          n_tests = 0;
  int          n_fail  = 0;

  dmem_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_size(p0_req_size),
    .p0_req_unsigned(p0_req_unsigned), .p0_resp_valid(p0_resp_valid),
    .p0_resp_rdata(p0_resp_rdata), .p0_resp_err(p0_resp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_size(p1_req_size),
    .p1_req_unsigned(p1_req_unsigned), .p1_resp_valid(p1_resp_valid),
    .p1_resp_rdata(p1_resp_rdata), .p1_resp_err(p1_resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM, one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      for (int j = 0; j < 4; j++) begin
        if (mem_we[j]) ram[mem_addr][8*j +: 8] <= mem_din[8*j +: 8];
      end
      mem_dout <= ram[mem_addr];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit tb_mis(input logic [1:0] sz, input logic [1:0] off);
`ifdef DMEM_ARB_ERR_EN
    if (sz == 2'b01) return off[0];
    if (sz[1]) return (off != 2'b00);
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'b00) return 4'b0001 << off;
    if (sz == 2'b01) return off[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_din(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b00) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    if (sz == 2'b01) return {wd[15:0], wd[15:0]};
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input bit un, input logic [1:0] off);
    logic [31:0] sh;
    if (sz == 2'b00) begin
      sh = w >> (8 * off);
      return un ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
    end
    if (sz == 2'b01) begin
      sh = w >> (16 * off[1]);
      return un ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
    end
    return w;
  endfunction

  task automatic set_port(input bit p, input bit v, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz, input bit un);
    if (p) begin
      p1_req_valid = v; p1_req_we = we; p1_req_addr = a; p1_req_wdata = wd;
      p1_req_size = sz; p1_req_unsigned = un;
    end else begin
      p0_req_valid = v; p0_req_we = we; p0_req_addr = a; p0_req_wdata = wd;
      p0_req_size = sz; p0_req_unsigned = un;
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_p0_ready"}, p0_req_ready, 0);
    check_val({tag, "_p1_ready"}, p1_req_ready, 0);
    check_val({tag, "_p0_rv"}, p0_resp_valid, 0);
    check_val({tag, "_p1_rv"}, p1_resp_valid, 0);
    check_val({tag, "_p0_rd"}, p0_resp_rdata, 0);
    check_val({tag, "_p1_rd"}, p1_resp_rdata, 0);
    check_val({tag, "_p0_err"}, p0_resp_err, 0);
    check_val({tag, "_p1_err"}, p1_resp_err, 0);
    check_val({tag, "_mem_en"}, mem_en, 0);
    check_val({tag, "_mem_we"}, mem_we, 0);
    check_val({tag, "_mem_addr"}, mem_addr, 0);
    check_val({tag, "_mem_din"}, mem_din, 0);
  endtask

  // One cycle: entered just after a falling edge with inputs already driven
  task automatic cycle();
    bit gv, g, we, un, mis, has;
    logic [31:0] a, wd, edin;
    logic [1:0] sz;
    logic [3:0] ewe;
    int idx;
    exp_t e;
    #1;
    gv = p0_req_valid || p1_req_valid;
    g  = (p0_req_valid && p1_req_valid) ? tb_prio : p1_req_valid;
    check_val("p0_ready", p0_req_ready, gv && !g);
    check_val("p1_ready", p1_req_ready, gv && g);
    if (gv) begin
      we = g ? p1_req_we : p0_req_we;
      a  = g ? p1_req_addr : p0_req_addr;
      wd = g ? p1_req_wdata : p0_req_wdata;
      sz = g ? p1_req_size : p0_req_size;
      un = g ? p1_req_unsigned : p0_req_unsigned;
      mis = tb_mis(sz, a[1:0]);
      idx = int'(a[AW+1:2]);
      check_val("mem_en", mem_en, !mis);
      if (!mis) check_val("mem_addr", mem_addr, a[AW+1:2]);
      ewe  = (we && !mis) ? model_be(sz, a[1:0]) : 4'b0000;
      edin = model_din(sz, wd);
      check_val("mem_we", mem_we, ewe);
      if (we && !mis) begin
        check_val("mem_din", mem_din, edin);
        for (int j = 0; j < 4; j++) begin
          if (ewe[j]) shadow[idx][8*j +: 8] = edin[8*j +: 8];
        end
      end
      if (mis) sb_q.push_back('{port: g, data: 32'h0, err: 1'b1});
      else if (!we) sb_q.push_back('{port: g, data: model_load(shadow[idx], sz, un, a[1:0]), err: 1'b0});
      tb_prio = !g;
    end else begin
      check_val("idle_mem_en", mem_en, 0);
      check_val("idle_mem_we", mem_we, 0);
    end
    @(posedge clk);
    #1;
    has = (sb_q.size() > 0);
    if (has) e = sb_q.pop_front();
    else e = '{port: 1'b0, data: 32'h0, err: 1'b0};
    check_val("p0_resp_valid", p0_resp_valid, has && !e.port);
    check_val("p1_resp_valid", p1_resp_valid, has && e.port);
    check_val("p0_resp_rdata", p0_resp_rdata, (has && !e.port) ? e.data : 32'h0);
    check_val("p1_resp_rdata", p1_resp_rdata, (has && e.port) ? e.data : 32'h0);
    check_val("p0_resp_err", p0_resp_err, has && !e.port && e.err);
    check_val("p1_resp_err", p1_resp_err, has && e.port && e.err);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]    = (i * 32'h0101_0101) ^ 32'hA5A5_5A5A;
      shadow[i] = (i * 32'h0101_0101) ^ 32'hA5A5_5A5A;
    end
    rst = 1'b0;
    set_port(0, 1, 1, 32'h44, 32'h1234_5678, 2'b10, 0);
    set_port(1, 1, 0, 32'h48, 32'h0, 2'b10, 0);
    @(negedge clk); #1;
    check_zero("rst_hold");
    @(negedge clk); #1;
    check_zero("rst_hold2");
    set_port(0, 0, 0, 32'h0, 32'h0, 2'b10, 0);
    set_port(1, 0, 0, 32'h0, 32'h0, 2'b10, 0);
    @(negedge clk);
    rst = 1'b1;
    tb_prio = 1'b0;

    // Both ports contend from reset: p0, p1, p0, p1
    set_port(0, 1, 0, 32'h20, 32'h0, 2'b10, 0);
    set_port(1, 1, 0, 32'h24, 32'h0, 2'b10, 0);
    for (int i = 0; i < 4; i++) cycle();
    set_port(0, 0, 0, 32'h0, 32'h0, 2'b10, 0);
    set_port(1, 0, 0, 32'h0, 32'h0, 2'b10, 0);
    cycle();

    // Byte/half store and load formatting on p0
    set_port(0, 1, 1, 32'h10, 32'h0000_0080, 2'b00, 0); cycle();
    set_port(0, 1, 0, 32'h10, 32'h0, 2'b00, 0);         cycle();
    set_port(0, 1, 0, 32'h10, 32'h0, 2'b00, 1);         cycle();
    set_port(0, 1, 1, 32'h12, 32'h0000_8080, 2'b01, 0); cycle();
    set_port(0, 1, 0, 32'h12, 32'h0, 2'b01, 1);         cycle();
    set_port(0, 1, 0, 32'h12, 32'h0, 2'b01, 0);         cycle();
    set_port(0, 0, 0, 32'h0, 32'h0, 2'b10, 0);          cycle();

    // p1 alone: three back-to-back loads
    set_port(1, 1, 0, 32'h10, 32'h0, 2'b00, 0); cycle();
    set_port(1, 1, 0, 32'h13, 32'h0, 2'b00, 1); cycle();
    set_port(1, 1, 0, 32'h30, 32'h0, 2'b11, 0); cycle();
    set_port(1, 0, 0, 32'h0, 32'h0, 2'b10, 0);  cycle();

`ifdef DMEM_ARB_ERR_EN
    set_port(0, 1, 0, 32'h06, 32'h0, 2'b10, 0);         cycle();
    set_port(0, 1, 1, 32'h11, 32'hDEAD_BEEF, 2'b01, 0); cycle();
    set_port(0, 0, 0, 32'h0, 32'h0, 2'b10, 0);          cycle();
`endif

    // Random mixed traffic, including idle cycles and size 2'b11
    for (int i = 0; i < 60; i++) begin
      set_port(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 63),
               $urandom, $urandom_range(0, 3), $urandom_range(0, 1));
      set_port(1, ($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 63),
               $urandom, $urandom_range(0, 3), $urandom_range(0, 1));
      cycle();
    end
    set_port(0, 0, 0, 32'h0, 32'h0, 2'b10, 0);
    set_port(1, 0, 0, 32'h0, 32'h0, 2'b10, 0);
    cycle();

    // Load granted, then reset lands before its response completes
    set_port(0, 1, 0, 32'h20, 32'h0, 2'b10, 0);
    #1;
    check_val("rst_load_ready", p0_req_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    set_port(0, 0, 0, 32'h0, 32'h0, 2'b10, 0);
    #1;
    check_zero("rst_inflight");
    @(posedge clk); #1;
    check_zero("rst_after_edge");
    @(negedge clk);
    rst = 1'b1;
    tb_prio = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 3; i++) cycle();

    // Pointer back at port 0 after reset
    set_port(0, 1, 0, 32'h20, 32'h0, 2'b10, 0);
    set_port(1, 1, 0, 32'h24, 32'h0, 2'b10, 0);
    cycle();
    cycle();
    set_port(0, 0, 0, 32'h0, 32'h0, 2'b10, 0);
    set_port(1, 0, 0, 32'h0, 32'h0, 2'b10, 0);
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 14, giving the RAM word-address width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have ports p<i>_req_valid (input, 1) and p<i>_req_ready (output, 1) for i=0 (CPU) and i=1 (DMA): the request handshake.
REQ-005 The block SHALL have ports p<i>_req_we (input, 1), p<i>_req_addr (input, 32, byte address) and p<i>_req_wdata (input, 32): the write flag, address and store data.
REQ-006 The block SHALL have ports p<i>_req_size (input, 2; 00 byte, 01 half, 10 word, 11 treated as word) and p<i>_req_unsigned (input, 1): the access size and load-extension mode.
REQ-007 The block SHALL have ports p<i>_resp_valid (output, 1) and p<i>_resp_rdata (output, 32): the formatted load response.
REQ-008 The block SHALL have ports mem_en (output, 1), mem_we (output, 4), mem_addr (output, ADDR_WIDTH) and mem_din (output, 32): the shared synchronous single-port RAM request.
REQ-009 The block SHALL have port mem_dout (input, 32): RAM read data, valid one cycle after mem_en.

Function
REQ-010 The block SHALL grant at most one request per cycle, and p<i>_req_ready SHALL be combinational and high only for the granted port.
REQ-011 The block SHALL grant the only valid port when one port is valid; when both are valid, it SHALL grant the port not granted most recently (round-robin).
REQ-012 The round-robin pointer SHALL update only on a grant, and SHALL be left unchanged on idle cycles.
REQ-013 The block SHALL drive mem_en=1 in the grant cycle with mem_addr=req_addr[ADDR_WIDTH+1:2].
REQ-014 Stores SHALL set mem_we as follows: byte -> 4'b0001<<addr[1:0]; half -> addr[1] ? 1100 : 0011; word -> 1111.
REQ-015 Store data on mem_din SHALL be the byte replicated ×4 for byte stores, the half replicated ×2 for half stores, and the word unchanged for word stores.
REQ-016 Loads SHALL drive mem_we=0000, and the block SHALL register port ID, size, unsigned flag and addr[1:0] for the response stage.
REQ-017 The block SHALL assert p<i>_resp_valid exactly one cycle after a load grant, for one cycle, only on the granted port; stores SHALL produce no response.
REQ-018 Load formatting SHALL select the byte or half lane by the registered offset and then zero-extend it if unsigned, or sign-extend it otherwise; word loads SHALL pass through unchanged.
REQ-019 Back-to-back grants SHALL be fully pipelined, giving a throughput of one access per cycle with no bubbles.
REQ-020 Without DMEM_ARB_ERR_EN, low address bits not needed for lane selection SHALL be ignored.
REQ-021 When p<i>_resp_valid is low, p<i>_resp_rdata SHALL be 0.

Reset
REQ-022 While rst=0, the block SHALL hold all outputs at 0 and point the round-robin pointer at port 0.
REQ-023 Reset asserted with a load in flight SHALL drop that response; no resp_valid SHALL appear after reset deasserts.

Configuration
REQ-024 Macro DMEM_ARB_ERR_EN SHALL add outputs p<i>_resp_err (1 bit), which are 0 when the macro is absent.
REQ-025 With DMEM_ARB_ERR_EN, a misaligned request (half with addr[0]=1, word with addr[1:0]≠0) SHALL still be granted.
REQ-026 With DMEM_ARB_ERR_EN, a misaligned request SHALL drive mem_en=0 and mem_we=0000.
REQ-027 With DMEM_ARB_ERR_EN, a misaligned request SHALL produce, one cycle later, resp_valid=1, resp_err=1 and rdata=0 for loads and stores alike.
REQ-028 Without DMEM_ARB_ERR_EN, misaligned accesses SHALL follow REQ-020.

Structure
REQ-029 Package dmem_pkg SHALL hold the size encodings (SIZE_B, SIZE_H, SIZE_W) and the RAM read-latency constant (1).
REQ-030 Byte-lane store/load formatting SHALL live in sub-module dmem_lane_fmt, which is purely combinational and instantiated once for stores and once for loads.

Verification
REQ-031 The bench SHALL cover: p0 store byte wdata=0x00000080 addr=0x10 -> mem_we=0001, mem_din=0x80808080; p0 load byte signed addr=0x10 -> resp_rdata=0xFFFFFF80 one cycle later.
REQ-032 The bench SHALL cover: p0 load byte unsigned addr=0x10 -> 0x00000080; p0 store half 0x8080 at addr=0x12 -> mem_we=1100; load half unsigned at 0x12 -> 0x00008080.
REQ-033 The bench SHALL cover: p0 and p1 both valid for 4 cycles from reset -> grants alternate p0,p1,p0,p1, with responses routed only to the issuing port.
REQ-034 The bench SHALL cover: p1 alone valid for 3 consecutive loads -> 3 consecutive grants, with resp_valid on cycles 2-4.
REQ-035 The bench SHALL cover: a load granted, then rst=0 on the next edge -> no resp_valid, and all outputs 0.
REQ-036 The bench SHALL cover, with DMEM_ARB_ERR_EN: word load at addr=0x06 -> mem_en=0, next cycle resp_valid=1, resp_err=1, rdata=0.
